// File: rtl/noc_inject_pkg.sv
// rtl/noc_inject_pkg.sv - flit format constants and FSM encoding for the local-port injection arbiter
package noc_inject_pkg;

   localparam int FLIT_W   = 35;
   localparam int TYPE_MSB = 34;
   localparam int TYPE_LSB = 32;
   localparam int DATA_W   = 16;

   localparam logic [2:0] FLIT_HEAD = 3'b001;
   localparam logic [2:0] FLIT_BODY = 3'b010;
   localparam logic [2:0] FLIT_TAIL = 3'b011;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - requester-side and router-side signals of the injection arbiter
interface noc_inject_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 4
);
   import noc_inject_pkg::*;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*ID_W-1:0]   req_dst;
   logic [N_REQ-1:0]        req_vch;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_dvalid;
   logic [N_REQ-1:0]        req_dlast;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        req_dready;

   logic [1:0]              ordy_p0;
   logic                    ivalid_p0;
   logic                    ivch_p0;
   logic [FLIT_W-1:0]       idata_p0;

   modport slave (
      input  req, req_dst, req_vch, req_data, req_dvalid, req_dlast, ordy_p0,
      output gnt, req_dready, ivalid_p0, ivch_p0, idata_p0
   );

   modport master (
      output req, req_dst, req_vch, req_data, req_dvalid, req_dlast, ordy_p0,
      input  gnt, req_dready, ivalid_p0, ivch_p0, idata_p0
   );

endinterface

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// rtl/noc_inject_arbiter_rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any
);

   int j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - round-robin local-port injection of head/body/tail flit packets
// Optional counters pkt_cnt/stall_cnt when NOC_INJ_STATS_EN is defined.
module noc_inject_arbiter
   import noc_inject_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 4
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [ID_W-1:0]     my_id,
   noc_inject_arbiter_if.slave bus,
   output logic                busy
`ifdef NOC_INJ_STATS_EN
   ,
   output logic [31:0]         pkt_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  cur;
   logic [N_REQ-1:0]  arb_grant;
   logic [PTR_W-1:0]  arb_idx;
   logic              arb_any;
   logic              transfer;
   logic              can_load;
   logic              tail_loaded;
   logic              start_pkt;
   logic              word_take;
   logic              end_pkt;
   logic [FLIT_W-1:0] head_flit;
   logic [FLIT_W-1:0] body_flit;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .req       (bus.req),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   assign transfer    = bus.ivalid_p0 && bus.ordy_p0[bus.ivch_p0];
   assign can_load    = !bus.ivalid_p0 || transfer;
   // Once the tail sits in the output register no further words belong to this packet.
   assign tail_loaded = bus.ivalid_p0 && (bus.idata_p0[TYPE_MSB:TYPE_LSB] == FLIT_TAIL);
   assign start_pkt   = (state == IDLE) && arb_any && can_load;
   assign word_take   = (state == DATA) && bus.req_dvalid[cur] && can_load && !tail_loaded;
   assign end_pkt     = (state == DATA) && transfer && tail_loaded;

   assign bus.req_dready = word_take ? bus.gnt : '0;
   assign busy           = (state != IDLE) || bus.ivalid_p0;

   always_comb begin
      head_flit                    = '0;
      head_flit[TYPE_MSB:TYPE_LSB] = FLIT_HEAD;
      head_flit[2*ID_W-1:ID_W]     = my_id;
      head_flit[ID_W-1:0]          = bus.req_dst[arb_idx*ID_W +: ID_W];
      body_flit                    = '0;
      body_flit[TYPE_MSB:TYPE_LSB] = bus.req_dlast[cur] ? FLIT_TAIL : FLIT_BODY;
      body_flit[DATA_W-1:0]        = bus.req_data[cur*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_pkt) state_nxt = DATA;
         DATA:    if (end_pkt)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         bus.gnt       <= '0;
         bus.ivalid_p0 <= 1'b0;
         bus.ivch_p0   <= 1'b0;
         bus.idata_p0  <= '0;
         rr_ptr        <= '0;
         cur           <= '0;
      end else if (start_pkt) begin
         bus.gnt       <= arb_grant;
         cur           <= arb_idx;
         bus.ivch_p0   <= bus.req_vch[arb_idx];
         bus.idata_p0  <= head_flit;
         bus.ivalid_p0 <= 1'b1;
      end else if (end_pkt) begin
         bus.gnt       <= '0;
         bus.ivalid_p0 <= 1'b0;
         rr_ptr        <= (cur == PTR_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
      end else if (word_take) begin
         bus.idata_p0  <= body_flit;
         bus.ivalid_p0 <= 1'b1;
      end else if (transfer) begin
         bus.ivalid_p0 <= 1'b0;
      end
   end

`ifdef NOC_INJ_STATS_EN
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         pkt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (end_pkt) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
         if (bus.ivalid_p0 && !bus.ordy_p0[bus.ivch_p0]) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
